// File: rtl/traffic_light_ctrl.sv
// Two-road intersection phase sequencer driving an external down-counter for phase timing.
// Optional pedestrian walk phase enabled by defining PED_WALK_EN.
module traffic_light_ctrl #(
    parameter int N        = 11,
    parameter int DUR_NS_G = 30,
    parameter int DUR_EW_G = 20,
    parameter int DUR_Y    = 3,
    parameter int DUR_AR   = 1
`ifdef PED_WALK_EN
    ,
    parameter int DUR_WALK = 10
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [N-1:0] cnt_q,
    output logic         cnt_load,
    output logic         cnt_en,
    output logic         cnt_dir,
    output logic [N-1:0] cnt_value,
    output logic [2:0]   ns_light,
    output logic [2:0]   ew_light
`ifdef PED_WALK_EN
    ,
    input  logic         ped_req,
    output logic         walk
`endif
);

    typedef enum logic [2:0] {
        S_NS_G,
        S_NS_Y,
        S_AR1,
        S_EW_G,
        S_EW_Y,
        S_AR2
`ifdef PED_WALK_EN
        ,
        S_WALK
`endif
    } state_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    state_t         r_state;
    logic           r_phase_start;
    logic [N-1:0]   r_cnt_value;
    logic [2:0]     r_ns_light;
    logic [2:0]     r_ew_light;
    state_t         w_next;
    logic           w_expire;
`ifdef PED_WALK_EN
    logic           r_walk;
    logic           r_ped_pending;
`endif

    function automatic logic [N-1:0] f_load_value(input state_t s);
        logic [N-1:0] v;
        case (s)
            S_NS_G:  v = N'(DUR_NS_G - 1);
            S_NS_Y:  v = N'(DUR_Y - 1);
            S_AR1:   v = N'(DUR_AR - 1);
            S_EW_G:  v = N'(DUR_EW_G - 1);
            S_EW_Y:  v = N'(DUR_Y - 1);
            S_AR2:   v = N'(DUR_AR - 1);
`ifdef PED_WALK_EN
            S_WALK:  v = N'(DUR_WALK - 1);
`endif
            default: v = N'(DUR_NS_G - 1);
        endcase
        return v;
    endfunction

    // Returns {ns_light, ew_light}
    function automatic logic [5:0] f_lamps(input state_t s);
        logic [5:0] l;
        case (s)
            S_NS_G:  l = {LAMP_G, LAMP_R};
            S_NS_Y:  l = {LAMP_Y, LAMP_R};
            S_EW_G:  l = {LAMP_R, LAMP_G};
            S_EW_Y:  l = {LAMP_R, LAMP_Y};
            default: l = {LAMP_R, LAMP_R};
        endcase
        return l;
    endfunction

    always_comb begin
        w_next = S_NS_G;
        case (r_state)
            S_NS_G:  w_next = S_NS_Y;
            S_NS_Y:  w_next = S_AR1;
            S_AR1:   w_next = S_EW_G;
            S_EW_G:  w_next = S_EW_Y;
            S_EW_Y:  w_next = S_AR2;
`ifdef PED_WALK_EN
            S_AR2:   w_next = r_ped_pending ? S_WALK : S_NS_G;
            S_WALK:  w_next = S_NS_G;
`else
            S_AR2:   w_next = S_NS_G;
`endif
            default: w_next = S_NS_G;
        endcase
    end

    // Counter output is stale during the load cycle, so it is ignored there.
    assign w_expire = ~r_phase_start & tick & (cnt_q == '0);
    assign cnt_en   = ~r_phase_start & tick & (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state                  <= S_NS_G;
            r_phase_start            <= 1'b1;
            r_cnt_value              <= f_load_value(S_NS_G);
            {r_ns_light, r_ew_light} <= f_lamps(S_NS_G);
`ifdef PED_WALK_EN
            r_walk                   <= 1'b0;
            r_ped_pending            <= 1'b0;
`endif
        end else begin
            r_phase_start <= w_expire;
            r_cnt_value   <= '0;
            if (w_expire) begin
                r_state                  <= w_next;
                r_cnt_value              <= f_load_value(w_next);
                {r_ns_light, r_ew_light} <= f_lamps(w_next);
`ifdef PED_WALK_EN
                r_walk                   <= (w_next == S_WALK);
`endif
            end
`ifdef PED_WALK_EN
            // A press coinciding with WALK entry is kept for the next cycle round.
            if (w_expire && (w_next == S_WALK)) begin
                r_ped_pending <= ped_req;
            end else if (ped_req) begin
                r_ped_pending <= 1'b1;
            end
`endif
        end
    end

    assign cnt_load  = r_phase_start;
    assign cnt_value = r_cnt_value;
    assign cnt_dir   = 1'b1;
    assign ns_light  = r_ns_light;
    assign ew_light  = r_ew_light;
`ifdef PED_WALK_EN
    assign walk      = r_walk;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl paired with a behavioural up/down counter with load.
// Walk-phase checks are compiled in when PED_WALK_EN is defined.
module tb_traffic_light_ctrl;

    typedef struct {
        logic [2:0]  ns;
        logic [2:0]  ew;
        logic        walk;
        logic [10:0] val;
        int          dur;
        int          cyc;
    } rec_t;

    logic        clk;
    logic        rst;
    logic        tick;
    logic [10:0] cnt_q;
    logic        cnt_load;
    logic        cnt_en;
    logic        cnt_dir;
    logic [10:0] cnt_value;
    logic [2:0]  ns_light;
    logic [2:0]  ew_light;
`ifdef PED_WALK_EN
    logic        ped_req;
    logic        walk;
`endif

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   mode     = 1;
    int   next_ph  = 0;

    traffic_light_ctrl #(
        .N(11),
        .DUR_NS_G(4),
        .DUR_EW_G(3),
        .DUR_Y(2),
        .DUR_AR(1)
`ifdef PED_WALK_EN
        ,
        .DUR_WALK(10)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .cnt_q(cnt_q),
        .cnt_load(cnt_load),
        .cnt_en(cnt_en),
        .cnt_dir(cnt_dir),
        .cnt_value(cnt_value),
        .ns_light(ns_light),
        .ew_light(ew_light)
`ifdef PED_WALK_EN
        ,
        .ped_req(ped_req),
        .walk(walk)
`endif
    );

    // External counter: no reset, load has priority, D=1 counts down
    always_ff @(posedge clk) begin
        if (cnt_load) cnt_q <= cnt_value;
        else if (cnt_en) cnt_q <= cnt_dir ? cnt_q - 11'd1 : cnt_q + 11'd1;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    endtask

    task automatic timeout(input string name);
        chk(name, 0, 1);
        finish_test();
    endtask

    // Phase index: 0 NS_G, 1 NS_Y, 2 AR1, 3 EW_G, 4 EW_Y, 5 AR2, 6 WALK
    function automatic rec_t ph_rec(input int idx);
        rec_t r;
        r.walk = 1'b0;
        r.cyc  = 0;
        case (idx)
            0: begin r.ns = 3'b001; r.ew = 3'b100; r.dur = 4;  end
            1: begin r.ns = 3'b010; r.ew = 3'b100; r.dur = 2;  end
            2: begin r.ns = 3'b100; r.ew = 3'b100; r.dur = 1;  end
            3: begin r.ns = 3'b100; r.ew = 3'b001; r.dur = 3;  end
            4: begin r.ns = 3'b100; r.ew = 3'b010; r.dur = 2;  end
            5: begin r.ns = 3'b100; r.ew = 3'b100; r.dur = 1;  end
            default: begin r.ns = 3'b100; r.ew = 3'b100; r.dur = 10; r.walk = 1'b1; end
        endcase
        r.val = 11'(r.dur - 1);
        return r;
    endfunction

    // Last phase of a group runs into the next tick mode, so its cycle length is unchecked
    task automatic push_phases(input int n, input int md, input bit with_walk);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            r = ph_rec(next_ph);
            if (i != n - 1) begin
                if (md == 1) r.cyc = r.dur + 1;
                else if (md == 5) r.cyc = 2 * r.dur + 1;
            end
            exp_q.push_back(r);
            if (next_ph == 5) next_ph = with_walk ? 6 : 0;
            else if (next_ph == 6) next_ph = 0;
            else next_ph++;
        end
    endtask

    task automatic wait_empty(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) timeout(name);
    endtask

    // Tick generator: 1 = every cycle, 3 = every third cycle, 5 = on load cycles and every 2nd cycle after
    initial begin : tick_gen
        int cyc   = 0;
        int since = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            since = cnt_load ? 0 : since + 1;
            case (mode)
                1:       tick = 1'b1;
                3:       tick = (cyc % 3 == 0);
                5:       tick = (since % 2 == 0);
                default: tick = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        rec_t        cur;
        bit          have_cur = 1'b0;
        bit          armed    = 1'b0;
        bit          rst_d    = 1'b0;
        int          ticks    = 0;
        int          cycles   = 0;
        logic [10:0] exp_next;
        exp_next = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (rst_d) begin
                    chk("rst_load", int'(cnt_load), 1);
                    chk("rst_value", int'(cnt_value), 3);
                    chk("rst_ns", int'(ns_light), 1);
                    chk("rst_ew", int'(ew_light), 4);
`ifdef PED_WALK_EN
                    chk("rst_walk", int'(walk), 0);
`endif
                end
                have_cur = 1'b0;
                armed    = 1'b0;
            end else begin
                if (armed) begin
                    chk("cnt_q_step", int'(cnt_q), int'(exp_next));
                    chk("cnt_q_no_wrap", int'(cnt_q == 11'd2047), 0);
                end
                chk("cnt_dir", int'(cnt_dir), 1);
                chk("en_at_zero", int'(cnt_en && cnt_q == '0), 0);
                if (cnt_load) begin
                    if (have_cur) begin
                        chk("phase_ticks", ticks, cur.dur);
                        if (cur.cyc != 0) chk("phase_cycles", cycles, cur.cyc);
                    end
                    if (exp_q.size() == 0) begin
                        chk("unexpected_phase_start", 0, 1);
                        have_cur = 1'b0;
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        chk("load_value", int'(cnt_value), int'(cur.val));
                    end
                    ticks    = 0;
                    cycles   = 1;
                    armed    = have_cur;
                    exp_next = cur.val;
                end else begin
                    cycles++;
                    if (tick) ticks++;
                    exp_next = (tick && cnt_q != '0) ? cnt_q - 11'd1 : cnt_q;
                end
                if (have_cur) begin
                    chk("ns_light", int'(ns_light), int'(cur.ns));
                    chk("ew_light", int'(ew_light), int'(cur.ew));
`ifdef PED_WALK_EN
                    chk("walk", int'(walk), int'(cur.walk));
`endif
                end
            end
            rst_d = rst;
        end
    end

    initial begin : stimulus
        bit found;
        rst = 1'b1;
`ifdef PED_WALK_EN
        ped_req = 1'b0;
`endif
        mode = 1;
        push_phases(7, 1, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_empty("timeout_full_cycle", 400);

        mode = 3;
        push_phases(6, 3, 1'b0);
        wait_empty("timeout_tick_every_3", 600);

        mode = 5;
        push_phases(6, 5, 1'b0);
        wait_empty("timeout_tick_on_load", 600);

        // Reset mid EW_G
        mode = 3;
        push_phases(3, 3, 1'b0);
        wait_empty("timeout_reach_ew_g", 400);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            if (ew_light == 3'b001 && cnt_q == 11'd1 && !cnt_load) found = 1'b1;
        end
        if (!found) timeout("timeout_ew_g_q1");
        rst     = 1'b1;
        next_ph = 0;
        push_phases(1, 3, 1'b0);
        @(posedge clk); #1;
        rst  = 1'b0;
        mode = 1;
        push_phases(6, 1, 1'b0);
        wait_empty("timeout_after_reset", 400);

`ifdef PED_WALK_EN
        push_phases(8, 1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            if (ew_light == 3'b001) found = 1'b1;
        end
        if (!found) timeout("timeout_ped_ew_g");
        ped_req = 1'b1;
        @(posedge clk); #1;
        ped_req = 1'b0;
        wait_empty("timeout_walk", 600);
        push_phases(6, 1, 1'b0);
        wait_empty("timeout_no_walk", 400);
`endif

        repeat (3) @(posedge clk);
        finish_test();
    end

endmodule
